// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - core data-memory port to valid/ready memory bus bridge
//
// Turns a single-cycle core load/store request into one bus transaction and
// stalls the core until it completes or times out.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   core_addr        byte address from the core
//   core_wdata       lane-aligned store data
//   core_be          store byte enables (nonzero = store request)
//   core_rd          load request (ignored when core_be is nonzero)
//   core_rdata       registered load data (holds last completed load)
//   core_stall       combinational stall back to the core
//   bus_valid/ready  request handshake
//   bus_we/addr/be/wdata  request payload, held from captured registers
//   bus_rvalid/rdata read return, only honoured while waiting for it
//   err              sticky timeout flag

module dmem_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_be,
    input  logic        core_rd,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_DONE
    } state_t;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        core_req;
    logic        last_cycle;
    logic [CW-1:0] cnt_inc;

    assign core_req = (core_be != 4'b0000) | core_rd;

    // The cycle whose increment brings the counter to TIMEOUT is the last one
    // allowed; once saturated, every further cycle is also a last cycle.
    assign last_cycle = (cnt_q >= CNT_LAST);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        core_stall = 1'b0;
        bus_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    core_stall = 1'b1;
                    // Any nonzero byte enable makes it a store; loads use all lanes.
                    addr_d  = {core_addr[31:2], 2'b00};
                    wdata_d = core_wdata;
                    we_d    = (core_be != 4'b0000);
                    be_d    = (core_be != 4'b0000) ? core_be : 4'b1111;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                core_stall = 1'b1;
                bus_valid  = 1'b1;
                cnt_d      = cnt_inc;
                // A handshake in the final allowed cycle still completes.
                if (bus_ready) begin
                    state_d = we_q ? S_DONE : S_WAIT_R;
                end else if (last_cycle) begin
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = ERR_RDATA;
                    end
                    state_d = S_DONE;
                end
            end

            S_WAIT_R: begin
                core_stall = 1'b1;
                cnt_d      = cnt_inc;
                if (bus_rvalid) begin
                    rdata_d = bus_rdata;
                    state_d = S_DONE;
                end else if (last_cycle) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // The core still shows the finished request here; ignore it.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign core_rdata = rdata_q;
    assign err        = err_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_be     = be_q;
    assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - scoreboard testbench for dmem_bridge

module tb_dmem_bridge;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_be;
    logic        core_rd;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        err;

    dmem_bridge #(
        .TIMEOUT   (TO),
        .ERR_RDATA (ERR_VAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_be    (core_be),
        .core_rd    (core_rd),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        int          stall;
        logic [31:0] rdata;
        logic        err;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference state: what the core should see after each transaction.
    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          run_len   = 0;
    logic        prev_wait = 1'b0;
    logic [36:0] prev_req  = '0;

    always @(negedge clk) begin
        if (rst) begin
            run_len   = 0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && bus_valid) begin
                check("req_stable", {27'b0, bus_we, bus_be} ^ {27'b0, prev_req[36:32]}, 32'h0);
                check("addr_stable", bus_addr, prev_req[31:0]);
            end
            prev_wait = bus_valid && !bus_ready;
            prev_req  = {bus_we, bus_be, bus_addr};

            if (bus_valid && bus_ready) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: actual addr=%h we=%b required none", bus_addr, bus_we);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_we", {31'b0, bus_we}, {31'b0, b.we});
                    check("beat_addr", bus_addr, b.addr);
                    check("beat_be", {28'b0, bus_be}, {28'b0, b.be});
                    if (b.we) check("beat_wdata", bus_wdata, b.wdata);
                end
            end

            if (core_stall) begin
                run_len++;
            end else if (run_len > 0) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: actual stall=%0d required none", run_len);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("stall_cycles", run_len, d.stall);
                    check("core_rdata", core_rdata, d.rdata);
                    check("err", {31'b0, err}, {31'b0, d.err});
                end
                run_len = 0;
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                         input logic rd_req, input int rdly, input int vdly, input logic [31:0] rdat);
        bit    store;
        int    hs;
        int    rv;
        int    lim;
        int    endc;
        bit    ok;
        int    k;
        bit    done;
        beat_t b;
        done_t d;

        store = (be != 4'b0000);
        hs    = rdly + 1;          // REQ cycle (1-based) in which ready is offered
        rv    = rdly + vdly + 2;   // cycle after entering REQ in which rvalid is offered
        if (hs <= TO) begin
            b.we    = store;
            b.addr  = addr & 32'hFFFF_FFFC;
            b.be    = store ? be : 4'b1111;
            b.wdata = wd;
            beat_q.push_back(b);
        end
        if (hs > TO) begin
            endc = TO;
            ok   = 1'b0;
        end else if (store) begin
            endc = hs;
            ok   = 1'b1;
        end else begin
            // A handshake in the last allowed cycle still earns one read-wait cycle.
            lim = (TO > hs + 1) ? TO : hs + 1;
            if (rv <= lim) begin
                endc = rv;
                ok   = 1'b1;
            end else begin
                endc = lim;
                ok   = 1'b0;
            end
        end
        if (!ok) m_err = 1'b1;
        if (!store) m_rdata = ok ? rdat : ERR_VAL;
        d.stall = 1 + endc;
        d.rdata = m_rdata;
        d.err   = m_err;
        done_q.push_back(d);

        @(posedge clk); #1;
        core_addr  = addr;
        core_wdata = wd;
        core_be    = be;
        core_rd    = rd_req;
        bus_ready  = 1'b0;
        bus_rvalid = 1'($urandom % 2);   // stray rvalid in IDLE must be ignored
        bus_rdata  = $urandom;
        k    = 0;
        done = 1'b0;
        for (int t = 0; t < 30 && !done; t++) begin
            @(negedge clk);
            if (!core_stall) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                k++;
                bus_ready  = (k == hs);
                bus_rvalid = !store && (k == rv);
                bus_rdata  = (!store && k == rv) ? rdat : $urandom;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: actual stall still high required completion within 30 cycles");
        end
        @(posedge clk); #1;
        core_be    = 4'b0000;
        core_rd    = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        core_addr  = '0;
        core_wdata = '0;
        core_be    = '0;
        core_rd    = 1'b0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rdata", core_rdata, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_valid", {31'b0, bus_valid}, 32'h0);
        check("rst_stall", {31'b0, core_stall}, 32'h0);

        // Directed cases
        issue(32'h0000_1003, 32'hAB00_0000, 4'b1000, 1'b0, 0, 0, 32'h0);         // store, 2 stall
        issue(32'h0000_2000, 32'h0, 4'b0000, 1'b1, 0, 0, 32'h1234_5678);         // load, 3 stall
        issue(32'h0000_3004, 32'h0, 4'b0000, 1'b1, 5, 0, 32'h0BAD_F00D);         // ready low 5 cycles
        issue(32'h0000_4000, 32'h0, 4'b0000, 1'b1, 0, 50, 32'h1111_1111);        // rvalid never: abort
        issue(32'h0000_5008, 32'h5555_AAAA, 4'b1111, 1'b1, 0, 0, 32'h2222_2222); // store+load = store
        issue(32'h0000_600C, 32'h6666_6666, 4'b0011, 1'b0, 7, 0, 32'h0);         // handshake on last cycle
        issue(32'h0000_7000, 32'h7777_7777, 4'b0100, 1'b0, 10, 0, 32'h0);        // store timeout in REQ
        issue(32'h0000_8000, 32'h0, 4'b0000, 1'b1, 7, 0, 32'h3333_3333);         // late handshake, rvalid next
        issue(32'h0000_9000, 32'h0, 4'b0000, 1'b1, 7, 1, 32'h4444_4444);         // late handshake, abort in WAIT_R
        issue(32'h0000_A000, 32'h0, 4'b0000, 1'b1, 0, 6, 32'h5A5A_5A5A);         // rvalid on last cycle

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          rdly;
            int          vdly;
            logic [3:0]  be;
            logic        rq;
            kind = $urandom % 3;
            rdly = ($urandom % 8 == 0) ? 9 : int'($urandom % 4);
            vdly = ($urandom % 8 == 0) ? 12 : int'($urandom % 4);
            be   = (kind == 1) ? 4'b0000 : 4'($urandom % 15 + 1);
            rq   = (kind != 0);
            issue($urandom, $urandom, be, rq, rdly, vdly, $urandom);
        end

        // Reset while waiting for read data; the late rvalid must not land.
        begin
            beat_t b;
            b.we    = 1'b0;
            b.addr  = 32'h0000_B000;
            b.be    = 4'b1111;
            b.wdata = 32'h0;
            beat_q.push_back(b);
        end
        @(posedge clk); #1;
        core_addr = 32'h0000_B000;
        core_be   = 4'b0000;
        core_rd   = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b1;
        @(posedge clk); #1;
        bus_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        core_rd    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hCAFE_F00D;
        m_rdata    = 32'h0;
        m_err      = 1'b0;
        @(negedge clk);
        check("rst_mid_stall", {31'b0, core_stall}, 32'h0);
        check("rst_mid_rdata", core_rdata, m_rdata);
        check("rst_mid_err", {31'b0, err}, {31'b0, m_err});
        check("rst_mid_valid", {31'b0, bus_valid}, 32'h0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_ignored", core_rdata, m_rdata);

        // Bridge must still work after the abandoned transaction.
        issue(32'h0000_C000, 32'h0, 4'b0000, 1'b1, 1, 1, 32'h7E57_0001);
        repeat (2) @(posedge clk);

        check("beats_left", beat_q.size(), 32'h0);
        check("dones_left", done_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in REQ+WAIT_R before abort.
REQ-002 Parameter ERR_RDATA, default 32'h0000_0000: core_rdata value returned on timeout abort.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 core_addr  input  32  byte address from core ALU.
REQ-006 core_wdata  input  32  store data, already lane-aligned by core.
REQ-007 core_be  input  4  store byte enables; nonzero means store request.
REQ-008 core_rd  input  1  load request.
REQ-009 core_rdata  output  32  registered load data to core sign-extension stage.
REQ-010 core_stall  output  1  holds core PC/instruction while high.
REQ-011 bus_valid  output  1  request valid to data memory bus.
REQ-012 bus_ready  input  1  bus accepts request when high with bus_valid.
REQ-013 bus_we  output  1  1 = write, 0 = read.
REQ-014 bus_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-015 bus_be  output  4  byte enables; 4'b1111 for reads.
REQ-016 bus_wdata  output  32  write data.
REQ-017 bus_rvalid  input  1  read data valid.
REQ-018 bus_rdata  input  32  read data.
REQ-019 err  output  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT_R, DONE.
REQ-021 IDLE: request = (core_be != 0) | core_rd; on request, capture addr/wdata/be/type into registers, next state REQ.
REQ-022 Store and load asserted together SHALL be treated as a store; core_rd ignored.
REQ-023 REQ: bus_valid=1 with bus_* driven from captured registers, stable until bus_ready sampled high.
REQ-024 REQ handshake (bus_valid & bus_ready): store -> DONE; load -> WAIT_R; bus_valid low from next cycle.
REQ-025 WAIT_R: on bus_rvalid, core_rdata <= bus_rdata, next state DONE.
REQ-026 bus_rvalid in any state other than WAIT_R SHALL be ignored.
REQ-027 DONE: one cycle, core_stall=0, core inputs ignored (core still presents same request), next state IDLE.
REQ-028 core_stall SHALL be combinational: (IDLE & request) | REQ | WAIT_R.
REQ-029 Minimum load latency with zero-wait bus: IDLE, REQ(ready=1), WAIT_R(rvalid=1), DONE = stall for 3 cycles.
REQ-030 core_rdata SHALL hold last completed load value until next load completes or abort.
REQ-031 Cycle counter SHALL clear on entry to REQ, increment each cycle in REQ or WAIT_R, saturate, never wrap.
REQ-032 Counter reaching TIMEOUT in REQ or WAIT_R: bus_valid deasserted, err <= 1, load sets core_rdata <= ERR_RDATA, next state DONE.
REQ-033 Handshake/rvalid in the same cycle counter reaches TIMEOUT SHALL win over abort.
REQ-034 err SHALL remain set until rst.

Reset
REQ-035 rst high: state IDLE, counter 0, core_rdata 0, err 0, captured registers 0, next cycle bus_valid=0.
REQ-036 rst during REQ or WAIT_R SHALL abandon the transaction without completing it; late bus_rvalid ignored.

Verification
REQ-037 Store addr 0x1003, be 4'b1000, wdata 0xAB00_0000, bus_ready=1 -> one bus beat addr 0x1000, we=1, be 1000; stall 2 cycles.
REQ-038 Load addr 0x2000, ready=1, rvalid next cycle with 0x1234_5678 -> core_rdata=0x1234_5678 in DONE; stall 3 cycles.
REQ-039 Load with bus_ready low 5 cycles -> bus_valid held, bus_addr/be constant all 5 cycles, completes normally.
REQ-040 Load, rvalid never asserted, TIMEOUT=8 -> abort after 8 cycles, err=1, core_rdata=ERR_RDATA, IDLE accepts next request.
REQ-041 core_be=4'b1111 and core_rd=1 together -> single write beat, no read.
REQ-042 rst pulsed in WAIT_R, then rvalid asserted -> state IDLE, core_rdata=0, stall=0, rvalid ignored.
